mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requestor channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter MAX_OUTST, default 4, maximum outstanding reads (power of 2, 2..16).
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  N_PORTS  per-port request valid.
- we_i  in  N_PORTS  per-port write (1) or read (0).
- addr_i  in  N_PORTS*ADDR_W  per-port address, packed, port 0 at LSBs.
- wdata_i  in  N_PORTS*DATA_W  per-port write data, packed.
- gnt_o  out  N_PORTS  per-port request accepted this cycle.
- rvalid_o  out  N_PORTS  per-port read data valid.
- rdata_o  out  DATA_W  read data, shared by all ports, qualified by rvalid_o.
- mem_req_o  out  1  unified memory request.
- mem_we_o  out  1  unified memory write.
- mem_addr_o  out  ADDR_W  unified memory address.
- mem_wdata_o  out  DATA_W  unified memory write data.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  memory read response valid, in request order.
- mem_rdata_i  in  DATA_W  memory read data.
- err_o  out  1  sticky protocol error flag.

Function
REQ-006 SHALL arbitrate round-robin: the winner is the first asserted req_i at or after pointer rr_ptr, searching upward with wrap from N_PORTS-1 to 0.
REQ-007 SHALL drive mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o combinationally from the winning port.
REQ-008 SHALL block a winning read, with mem_req_o=0, when the order FIFO holds MAX_OUTST entries; a winning write SHALL still issue.
REQ-009 SHALL treat a blocked read as non-winning, so arbitration continues to the next eligible port in the same cycle.
REQ-010 SHALL assert gnt_o[w]=mem_gnt_i for winner w only, the same cycle, with zero added latency.
REQ-011 SHALL, on an accepted handshake (mem_req_o and mem_gnt_i), set rr_ptr to (w+1) mod N_PORTS at the next edge; otherwise rr_ptr holds.
REQ-012 SHALL push the winner index into the order FIFO on each accepted read; accepted writes SHALL push nothing and produce no response.
REQ-013 SHALL, on mem_rvalid_i with a non-empty FIFO, assert rvalid_o[head] and pass mem_rdata_i to rdata_o combinationally, then pop.
REQ-014 SHALL allow a push and a pop in the same cycle, leaving the count unchanged; a push while full cannot occur (REQ-008).
REQ-015 SHALL ignore mem_rvalid_i when the FIFO is empty, hold rvalid_o at 0, and set err_o to 1 until reset.
REQ-016 SHALL require each requestor to hold req_i, we_i, addr_i and wdata_i stable until it sees gnt_o; the arbiter SHALL NOT latch requests.
REQ-017 SHALL drive rdata_o to 0 when no rvalid_o bit is asserted.

Reset
REQ-018 SHALL, while rst=1 (asynchronous assert), set rr_ptr=0, FIFO count, read pointer and write pointer=0, and err_o=0.
REQ-019 SHALL, under reset, force gnt_o, rvalid_o and mem_req_o to 0, and mem_we_o, mem_addr_o and mem_wdata_o to 0.
REQ-020 SHALL discard outstanding reads on reset mid-operation; a later mem_rvalid_i with an empty FIFO SHALL set err_o per REQ-015.

Configuration
REQ-021 SHALL, with macro MEM_ARB_WSTRB_EN defined, add input wstrb_i (N_PORTS*DATA_W/8) and output mem_wstrb_o (DATA_W/8), muxed like wdata and forced to 0 on reads and under reset.
REQ-022 SHALL, without MEM_ARB_WSTRB_EN, have neither port; writes are full-word.

Structure
REQ-023 SHALL place default parameter values, the port-index width (clog2 of N_PORTS, minimum 1) and the FIFO count width in package mem_arb_pkg.
REQ-024 SHALL implement the order FIFO as sub-module mem_arb_fifo, parametrised by entry width and depth, with push, pop, full and empty signals.

Verification
REQ-025 SHALL cover: N_PORTS=2, both ports read continuously, mem_gnt_i=1 -> grants alternate 0,1,0,1 and responses route in order.
REQ-026 SHALL cover: MAX_OUTST=4, 4 reads accepted, no mem_rvalid_i -> 5th read blocked with mem_req_o=0, while a write from another port is granted.
REQ-027 SHALL cover: FIFO full, accepted write plus mem_rvalid_i in the same cycle -> one pop, count 3, next read accepted the following cycle.
REQ-028 SHALL cover: mem_rvalid_i with an empty FIFO -> rvalid_o=0 and err_o=1, held until rst.
REQ-029 SHALL cover: rst pulsed with 2 reads outstanding -> outputs 0 immediately, rr_ptr=0, count=0, and the first post-reset grant goes to the lowest requesting port.
REQ-030 SHALL cover: MEM_ARB_WSTRB_EN defined, port 1 writes with wstrb=4'b0011 -> mem_wstrb_o=4'b0011; on a read, mem_wstrb_o=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Purpose : Shared defaults and width helpers for the memory arbiter and its
//           read-order FIFO.
// Contents: default parameter values, port-index width (clog2 of N_PORTS,
//           never below 1) and FIFO occupancy-count width.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned DEF_N_PORTS   = 2;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_OUTST = 4;

    // Width of a port index; a single port still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    // Occupancy counter width; one extra bit so "full" (== depth) fits.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_fifo.sv
// -----------------------------------------------------------------------------
// mem_arb_fifo
// Purpose : Order FIFO holding the requesting port index of every accepted
//           read, so responses (which return in request order) can be routed.
// Ports   : clk, rst (async, active-high)
//           push_i/din_i  - write an entry (ignored when full)
//           pop_i         - drop the head entry (ignored when empty)
//           dout_o        - head entry, valid while !empty_o
//           full_o/empty_o- occupancy flags
// -----------------------------------------------------------------------------
module mem_arb_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = DEF_MAX_OUTST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from the same pre-edge values.
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is defined solely by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
// Purpose : Round-robin arbiter merging N_PORTS request channels onto a single
//           memory port. Reads are tracked in an order FIFO (mem_arb_fifo) so
//           in-order responses are steered back to the requesting port.
// Ports   : clk, rst (async, active-high)
//           req_i/we_i/addr_i/wdata_i - per-port requests, packed, port 0 LSBs
//           gnt_o       - per-port acceptance, same cycle as mem_gnt_i
//           rvalid_o/rdata_o - per-port response valid, shared read data
//           mem_*       - unified memory request/response interface
//           err_o       - sticky: response arrived with nothing outstanding
// Config  : define MEM_ARB_WSTRB_EN to add wstrb_i / mem_wstrb_o byte strobes.
// -----------------------------------------------------------------------------
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_PORTS   = DEF_N_PORTS,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_i,
    input  logic [N_PORTS-1:0]          we_i,
    input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [N_PORTS*DATA_W-1:0]   wdata_i,
`ifdef MEM_ARB_WSTRB_EN
    input  logic [N_PORTS*DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W/8-1:0]         mem_wstrb_o,
`endif
    output logic [N_PORTS-1:0]          gnt_o,
    output logic [N_PORTS-1:0]          rvalid_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic                        err_o
);

    localparam int unsigned IDX_W  = idx_w(N_PORTS);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   win_idx, head_idx, cand;
    logic [IDX_W:0]     sum;
    logic               win_found, issue, handshake;
    logic               push, pop, fifo_full, fifo_empty;
    logic               err_q, err_d;
    logic [N_PORTS-1:0] eligible;

    // A read is ineligible while the order FIFO is full, so it drops out of
    // the search and a later port (e.g. a write) can win in the same cycle.
    assign eligible = req_i & (we_i | {N_PORTS{~fifo_full}});

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            // NOTE: blocking assignments here so later iterations see the
            // updated search state within the same evaluation.
            sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_PORTS)) sum = sum - (IDX_W+1)'(N_PORTS);
            cand = sum[IDX_W-1:0];
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign issue     = win_found & ~rst;
    assign handshake = issue & mem_gnt_i;
    assign push      = handshake & ~we_i[win_idx];
    // Responses with nothing outstanding are dropped (and flagged below).
    assign pop       = mem_rvalid_i & ~fifo_empty & ~rst;

    always_comb begin
        mem_req_o   = issue;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        gnt_o       = '0;
        if (issue) begin
            mem_we_o    = we_i[win_idx];
            mem_addr_o  = addr_i[win_idx*ADDR_W +: ADDR_W];
            mem_wdata_o = wdata_i[win_idx*DATA_W +: DATA_W];
            gnt_o[win_idx] = mem_gnt_i;
        end
    end

`ifdef MEM_ARB_WSTRB_EN
    always_comb begin
        mem_wstrb_o = '0;
        if (issue && we_i[win_idx]) mem_wstrb_o = wstrb_i[win_idx*STRB_W +: STRB_W];
    end
`endif

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (pop) begin
            rvalid_o[head_idx] = 1'b1;
            rdata_o            = mem_rdata_i;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (win_idx == IDX_W'(N_PORTS - 1)) ? '0 : win_idx + 1'b1;
        end
        err_d = err_q | (mem_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

    mem_arb_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTST)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (win_idx),
        .dout_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
// Purpose : Directed bench for mem_arb (N_PORTS=2, 32-bit, MAX_OUTST=4).
//           Stimulus pushes hand-computed grants and responses into queues; a
//           negedge monitor pops and compares whenever the DUT hands over a
//           request or a read response.
// -----------------------------------------------------------------------------
module tb_mem_arb;

    localparam int unsigned N_PORTS   = 2;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_OUTST = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_PORTS-1:0]        req_i, we_i;
    logic [N_PORTS*ADDR_W-1:0] addr_i;
    logic [N_PORTS*DATA_W-1:0] wdata_i;
    logic [N_PORTS-1:0]        gnt_o, rvalid_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      mem_req_o, mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic                      mem_gnt_i, mem_rvalid_i;
    logic [DATA_W-1:0]         mem_rdata_i;
    logic                      err_o;
`ifdef MEM_ARB_WSTRB_EN
    logic [N_PORTS*DATA_W/8-1:0] wstrb_i;
    logic [DATA_W/8-1:0]         mem_wstrb_o;
`endif

    always #5 clk = ~clk;

    mem_arb #(
        .N_PORTS   (N_PORTS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
`ifdef MEM_ARB_WSTRB_EN
        .wstrb_i      (wstrb_i),
        .mem_wstrb_o  (mem_wstrb_o),
`endif
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_exp_t;

    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT completes a handshake or
    // presents a read response.
    always @(negedge clk) begin : monitor
        gnt_exp_t ge;
        rsp_exp_t re;
        if (!rst) begin
            if (mem_req_o && mem_gnt_i) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_handshake", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ge = gnt_q.pop_front();
                    check("gnt_o", 64'(gnt_o), 64'(1) << ge.port);
                    check("mem_we_o", 64'(mem_we_o), 64'(ge.we));
                    check("mem_addr_o", 64'(mem_addr_o), 64'(ge.addr));
                    if (ge.we) check("mem_wdata_o", 64'(mem_wdata_o), 64'(ge.wdata));
                end
            end
            if (|rvalid_o) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(rvalid_o), 64'h0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rvalid_o", 64'(rvalid_o), 64'(1) << re.port);
                    check("rdata_o", 64'(rdata_o), 64'(re.data));
                end
            end
        end
    end

    // One clock of stimulus: drive after the rising edge, register the
    // expected grant (g_port) and response (r_port), return at the falling edge.
    task automatic step(input logic [1:0] req, input logic [1:0] we,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input int g_port, input int r_port);
        gnt_exp_t ge;
        rsp_exp_t re;
        @(posedge clk);
        #1;
        req_i        = req;
        we_i         = we;
        addr_i       = {a1, a0};
        wdata_i      = {~wd, wd};
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        if (g_port >= 0) begin
            ge.port  = g_port;
            ge.we    = (g_port == 0) ? we[0] : we[1];
            ge.addr  = (g_port == 0) ? a0 : a1;
            ge.wdata = (g_port == 0) ? wd : ~wd;
            gnt_q.push_back(ge);
        end
        if (r_port >= 0) begin
            re.port = r_port;
            re.data = rd;
            rsp_q.push_back(re);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rv, input logic [31:0] rd, input int r_port);
        step(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, rv, rd, -1, r_port);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst          = 1'b1;
        req_i        = 2'b11;
        we_i         = 2'b11;
        addr_i       = {32'hAAAA_0001, 32'h5555_0000};
        wdata_i      = {32'h1234_5678, 32'h9ABC_DEF0};
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
`ifdef MEM_ARB_WSTRB_EN
        wstrb_i      = 8'hFF;
`endif

        // Reset holds every output at zero despite active inputs.
        #12;
        check("rst_gnt_o", 64'(gnt_o), 64'h0);
        check("rst_rvalid_o", 64'(rvalid_o), 64'h0);
        check("rst_rdata_o", 64'(rdata_o), 64'h0);
        check("rst_mem_req_o", 64'(mem_req_o), 64'h0);
        check("rst_mem_we_o", 64'(mem_we_o), 64'h0);
        check("rst_mem_addr_o", 64'(mem_addr_o), 64'h0);
        check("rst_mem_wdata_o", 64'(mem_wdata_o), 64'h0);
        check("rst_err_o", 64'(err_o), 64'h0);
        @(posedge clk);
        #1;
        req_i        = '0;
        we_i         = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        rst          = 1'b0;

        // Both ports read continuously: grants alternate 0,1,0,1 and the
        // one-cycle-later responses route 0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            step((k < 4) ? 2'b11 : 2'b00, 2'b00, 32'h100, 32'h200, 32'h0, 1'b1,
                 (k >= 1 && k <= 4), 32'hD000_0000 + 32'(k),
                 (k < 4) ? (k % 2) : -1, (k >= 1 && k <= 4) ? ((k - 1) % 2) : -1);
        end
        check("alt_err_o", 64'(err_o), 64'h0);

        // Fill the FIFO with four reads (ports 0,1,0,1).
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 2'b00, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 32'h0, 1'b1, 1'b0, 32'h0,
                 k % 2, -1);
        end
        // A lone fifth read is blocked.
        step(2'b01, 2'b00, 32'h1004, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, -1, -1);
        check("full_mem_req_o", 64'(mem_req_o), 64'h0);
        check("full_gnt_o", 64'(gnt_o), 64'h0);
        // Blocked read skipped, port 1 write issues; a response pops port 0.
        step(2'b11, 2'b10, 32'h1004, 32'h2F00, 32'h5A5A_0000, 1'b1, 1'b1, 32'hA0A0_0000, 1, 0);
        check("full_wr_mem_req_o", 64'(mem_req_o), 64'h1);
        check("full_wr_mem_we_o", 64'(mem_we_o), 64'h1);
        // Count now 3, so the pending port 0 read goes through.
        step(2'b01, 2'b00, 32'h1004, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 0, -1);
        check("refill_mem_req_o", 64'(mem_req_o), 64'h1);
        // Drain: order is 1,0,1,0.
        for (int k = 0; k < 4; k++) begin
            idle(1'b1, 32'hB000_0000 + 32'(k), (k % 2 == 0) ? 1 : 0);
        end

        // Two reads outstanding (pointer at 1: ports 1 then 0), then reset.
        step(2'b11, 2'b00, 32'h3000, 32'h3100, 32'h0, 1'b1, 1'b0, 32'h0, 1, -1);
        step(2'b11, 2'b00, 32'h3000, 32'h3100, 32'h0, 1'b1, 1'b0, 32'h0, 0, -1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_mem_req_o", 64'(mem_req_o), 64'h0);
        check("midrst_gnt_o", 64'(gnt_o), 64'h0);
        check("midrst_mem_addr_o", 64'(mem_addr_o), 64'h0);
        @(posedge clk);
        #1;
        req_i     = '0;
        mem_gnt_i = 1'b0;
        rst       = 1'b0;
        // Pointer back to 0: port 0 wins; its response is the FIFO head.
        step(2'b11, 2'b00, 32'h3200, 32'h3300, 32'h0, 1'b1, 1'b0, 32'h0, 0, -1);
        idle(1'b1, 32'hC0DE_0001, 0);
        check("postrst_err_o", 64'(err_o), 64'h0);

`ifdef MEM_ARB_WSTRB_EN
        wstrb_i = 8'b0011_1111;
        step(2'b10, 2'b10, 32'h0, 32'h4000, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h0, 1, -1);
        check("wstrb_write", 64'(mem_wstrb_o), 64'h3);
        step(2'b10, 2'b00, 32'h0, 32'h4004, 32'h0, 1'b1, 1'b0, 32'h0, 1, -1);
        check("wstrb_read", 64'(mem_wstrb_o), 64'h0);
        idle(1'b1, 32'hC0DE_0002, 1);
`endif

        // Response with nothing outstanding: dropped and flagged until reset.
        idle(1'b1, 32'hEEEE_EEEE, -1);
        check("spur_rvalid_o", 64'(rvalid_o), 64'h0);
        check("spur_rdata_o", 64'(rdata_o), 64'h0);
        idle(1'b0, 32'h0, -1);
        check("spur_err_set", 64'(err_o), 64'h1);
        repeat (3) idle(1'b0, 32'h0, -1);
        check("spur_err_held", 64'(err_o), 64'h1);
        rst = 1'b1;
        #1;
        check("spur_err_cleared", 64'(err_o), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        idle(1'b0, 32'h0, -1);
        check("gnt_queue_drained", 64'(gnt_q.size()), 64'h0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
